// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by spi_slave and spi_master.
//   SPI_WORD_SIZE : default bits per SPI word
//   SPI_TX_IDLE   : word driven on miso when no tx word is queued
//                   (truncated to the word size at the point of use)
//   ST_IDLE/ST_ACTIVE : link FSM state encodings
`timescale 1ns/1ps
package spi_pkg;

   localparam int unsigned SPI_WORD_SIZE = 8;
   localparam logic [15:0] SPI_TX_IDLE   = 16'hFFFF;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchroniser for one asynchronous pin, followed by a
// previous-value flop that provides edge detection.
//   clk   in  system clock
//   rst   in  synchronous active-high reset; every flop clears to 0
//   din   in  asynchronous pin
//   level out synchronised level
//   rise  out one-cycle pulse on a synchronised 0->1 transition
//   fall  out one-cycle pulse on a synchronised 1->0 transition
`timescale 1ns/1ps
module spi_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic prev;

   // Clearing to 0 means a chip select held low across reset does not produce
   // a falling edge; the slave waits for a fresh select.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   always_comb begin
      level = sync;
      rise  = sync & ~prev;
      fall  = ~sync & prev;
   end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 responder (CPOL=0, CPHA=0), MSB first, one chip select.
//   clk, rst    system clock, synchronous active-high reset
//   sck, cs_n, mosi  asynchronous SPI pins from the master
//   miso, miso_oe    slave data out and pad output enable (high while selected)
//   tx_data/tx_valid/tx_ready  parallel word into the tx holding register
//   rx_data/rx_valid           last complete received word, one-cycle strobe
//   tx_underrun                pulse when tx_idle is substituted at a word start
`timescale 1ns/1ps
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned          word_size = SPI_WORD_SIZE,
   parameter logic [word_size-1:0] tx_idle   = word_size'(SPI_TX_IDLE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sck,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   input  logic [word_size-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [word_size-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 tx_underrun
);

   localparam int unsigned CW = $clog2(word_size + 1);

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_level_unused, cs_rise, cs_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   logic [0:0]           state;
   logic [CW-1:0]        count;
   logic [word_size-1:0] shift_in;
   logic [word_size-1:0] shift_out;
   logic [word_size-1:0] hold;
   logic                 hold_full;
   logic                 take_word;

   spi_sync u_sync_sck (
      .clk   (clk),
      .rst   (rst),
      .din   (sck),
      .level (sck_level_unused),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_sync u_sync_cs (
      .clk   (clk),
      .rst   (rst),
      .din   (cs_n),
      .level (cs_level_unused),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync u_sync_mosi (
      .clk   (clk),
      .rst   (rst),
      .din   (mosi),
      .level (mosi_sync),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   // A new tx word is needed on select and on the falling sck that closes
   // each word (count has wrapped to 0). A simultaneous cs_rise cancels it.
   always_comb begin
      take_word = 1'b0;
      if (state == ST_IDLE)
         take_word = cs_fall;
      else if (!cs_rise && sck_fall && count == '0)
         take_word = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         hold        <= '0;
         hold_full   <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;

         // Load only when empty; a take in the same cycle finds it empty and
         // substitutes tx_idle, so the two never contend for hold_full.
         if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end

         if (take_word) begin
            if (hold_full) begin
               shift_out <= hold;
               hold_full <= 1'b0;
            end else begin
               shift_out   <= tx_idle;
               tx_underrun <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               count <= '0;
               if (cs_fall)
                  state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state <= ST_IDLE;
                  count <= '0;
               end else if (sck_rise) begin
                  shift_in <= {shift_in[word_size-2:0], mosi_sync};
                  if (count == CW'(word_size - 1)) begin
                     rx_data  <= {shift_in[word_size-2:0], mosi_sync};
                     rx_valid <= 1'b1;
                     count    <= '0;
                  end else begin
                     count <= count + CW'(1);
                  end
               end else if (sck_fall && count != '0) begin
                  shift_out <= {shift_out[word_size-2:0], 1'b0};
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      miso     = shift_out[word_size-1];
      miso_oe  = (state == ST_ACTIVE);
      tx_ready = ~hold_full;
   end

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

   logic       clk = 1'b0;
   logic       rst, sck, cs_n, mosi;
   logic       miso, miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun;

   int n_cmp = 0;
   int n_err = 0;
   int rx_cnt = 0;
   int und_cnt = 0;
   int r0, u0;
   logic [7:0] mi;
   logic [7:0] exp_rx_q[$];
   logic [7:0] exp_miso_q[$];

   always #5 clk = ~clk;

   spi_slave dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_underrun (tx_underrun)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_load(input logic [7:0] d);
      int unsigned n = 0;
      while (!tx_ready && n < 20) begin
         wait_clk(1);
         n++;
      end
      if (!tx_ready) check("tx_ready_timeout", 16'(tx_ready), 16'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
   endtask

   // Mode-0 master: mosi set while sck low, miso sampled just before the rise.
   task automatic master_word(input logic [7:0] mo, input int unsigned nbits,
                              input logic do_load, input logic [7:0] ld,
                              input int unsigned ld_bit, output logic [7:0] got);
      got = '0;
      for (int unsigned i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         if (do_load && i == ld_bit) begin
            tx_load(ld);
            wait_clk(4);
         end else begin
            wait_clk(5);
         end
         got  = {got[6:0], miso};
         sck  = 1'b1;
         wait_clk(5);
         sck  = 1'b0;
      end
   endtask

   task automatic check_miso(input string tag, input logic [7:0] got);
      if (exp_miso_q.size() == 0)
         check({tag, "_queue_empty"}, 16'd1, 16'd0);
      else
         check(tag, 16'(got), 16'(exp_miso_q.pop_front()));
   endtask

   // Scoreboard side: every rx_valid pulse consumes one expected word.
   always @(negedge clk) begin
      if (tx_underrun) und_cnt++;
      if (rx_valid) begin
         rx_cnt++;
         if (exp_rx_q.size() == 0)
            check("rx_unexpected", 16'(rx_data), 16'hFFFF);
         else
            check("rx_word", 16'(rx_data), 16'(exp_rx_q.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      tx_valid = 1'b0; tx_data = '0;

      // Reset state and idle bus activity
      wait_clk(3);
      check("rst_miso_oe", 16'(miso_oe), 16'd0);
      check("rst_tx_ready", 16'(tx_ready), 16'd1);
      check("rst_rx_valid", 16'(rx_valid), 16'd0);
      check("rst_rx_data", 16'(rx_data), 16'd0);
      check("rst_miso", 16'(miso), 16'd0);
      check("rst_underrun", 16'(tx_underrun), 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mosi = i[0];
         sck  = ~sck;
         wait_clk(5);
      end
      check("idle_no_rx", 16'(rx_cnt), 16'd0);
      check("idle_miso_oe", 16'(miso_oe), 16'd0);
      check("idle_no_underrun", 16'(und_cnt), 16'd0);

      // Single word, plus a load attempt while the holding register is full
      u0 = und_cnt; r0 = rx_cnt;
      tx_load(8'hA5);
      check("single_tx_ready_low", 16'(tx_ready), 16'd0);
      tx_data = 8'h00; tx_valid = 1'b1; wait_clk(1); tx_valid = 1'b0;
      exp_miso_q.push_back(8'hA5);
      exp_rx_q.push_back(8'h3C);
      cs_n = 1'b0; wait_clk(5);
      check("single_miso_oe", 16'(miso_oe), 16'd1);
      check("single_no_underrun_at_start", 16'(und_cnt - u0), 16'd0);
      master_word(8'h3C, 8, 1'b0, 8'h00, 0, mi);
      check_miso("single_miso", mi);
      wait_clk(5); cs_n = 1'b1; wait_clk(10);
      check("single_rx_pulses", 16'(rx_cnt - r0), 16'd1);
      check("single_rx_data", 16'(rx_data), 16'h3C);
      check("single_tx_ready", 16'(tx_ready), 16'd1);
      check("single_miso_oe_off", 16'(miso_oe), 16'd0);
      check("single_end_underrun", 16'(und_cnt - u0), 16'd1);

      // Underrun: nothing queued
      u0 = und_cnt;
      exp_miso_q.push_back(8'hFF);
      exp_rx_q.push_back(8'h81);
      cs_n = 1'b0; wait_clk(5);
      check("underrun_at_cs_fall", 16'(und_cnt - u0), 16'd1);
      master_word(8'h81, 8, 1'b0, 8'h00, 0, mi);
      check_miso("underrun_miso", mi);
      wait_clk(5); cs_n = 1'b1; wait_clk(10);
      check("underrun_rx_data", 16'(rx_data), 16'h81);
      check("underrun_total", 16'(und_cnt - u0), 16'd2);

      // Back-to-back words, second tx word loaded mid-word
      u0 = und_cnt; r0 = rx_cnt;
      tx_load(8'h11);
      exp_miso_q.push_back(8'h11); exp_miso_q.push_back(8'h22);
      exp_rx_q.push_back(8'hF0);   exp_rx_q.push_back(8'h0F);
      cs_n = 1'b0; wait_clk(5);
      master_word(8'hF0, 8, 1'b1, 8'h22, 3, mi);
      check_miso("b2b_miso0", mi);
      master_word(8'h0F, 8, 1'b0, 8'h00, 0, mi);
      check_miso("b2b_miso1", mi);
      wait_clk(5); cs_n = 1'b1; wait_clk(10);
      check("b2b_rx_pulses", 16'(rx_cnt - r0), 16'd2);
      check("b2b_underrun", 16'(und_cnt - u0), 16'd1);

      // Abort after 5 bits; cs_n rises together with the last sck fall.
      // A word queued during the aborted transfer must survive it.
      r0 = rx_cnt;
      cs_n = 1'b0; wait_clk(5);
      master_word(8'hC3, 5, 1'b1, 8'h77, 2, mi);
      cs_n = 1'b1; wait_clk(10);
      check("abort_no_rx", 16'(rx_cnt - r0), 16'd0);
      check("abort_count", 16'(dut.count), 16'd0);
      check("abort_miso_oe", 16'(miso_oe), 16'd0);
      check("abort_hold_kept", 16'(tx_ready), 16'd0);
      exp_miso_q.push_back(8'h77);
      exp_rx_q.push_back(8'h5A);
      cs_n = 1'b0; wait_clk(5);
      master_word(8'h5A, 8, 1'b0, 8'h00, 0, mi);
      check_miso("abort_next_miso", mi);
      wait_clk(5); cs_n = 1'b1; wait_clk(10);
      check("abort_next_rx", 16'(rx_data), 16'h5A);
      check("abort_next_rx_pulses", 16'(rx_cnt - r0), 16'd1);

      // Reset mid-word with a word in the holding register
      r0 = rx_cnt;
      cs_n = 1'b0; wait_clk(5);
      master_word(8'hE7, 3, 1'b1, 8'h99, 1, mi);
      check("rstmid_hold_full", 16'(tx_ready), 16'd0);
      rst = 1'b1; wait_clk(2); rst = 1'b0; wait_clk(1);
      check("rstmid_miso_oe", 16'(miso_oe), 16'd0);
      check("rstmid_tx_ready", 16'(tx_ready), 16'd1);
      check("rstmid_count", 16'(dut.count), 16'd0);
      check("rstmid_no_rx", 16'(rx_cnt - r0), 16'd0);
      cs_n = 1'b1; wait_clk(10);
      tx_load(8'h6C);
      exp_miso_q.push_back(8'h6C);
      exp_rx_q.push_back(8'h3A);
      cs_n = 1'b0; wait_clk(5);
      master_word(8'h3A, 8, 1'b0, 8'h00, 0, mi);
      check_miso("rstmid_next_miso", mi);
      wait_clk(5); cs_n = 1'b1; wait_clk(10);
      check("rstmid_next_rx", 16'(rx_data), 16'h3A);
      check("rstmid_next_rx_pulses", 16'(rx_cnt - r0), 16'd1);

      check("rx_queue_drained", 16'(exp_rx_q.size()), 16'd0);
      check("miso_queue_drained", 16'(exp_miso_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
